// File: rtl/Pkg_Global.sv
// Global constants shared across blocks.
// LENGTH is the default shift-register word width used by shift_ctrl.
package Pkg_Global;

  localparam int LENGTH = 8;

endpackage

// File: rtl/shift_ctrl.sv
// shift_ctrl: serial-to-parallel capture controller.
//
// A start request clears the shift register and bit counter and enters SHIFT.
// In SHIFT, every cycle with bin_valid=1 shifts bin into the LSB, so the first
// accepted bit ends up at the MSB. After WIDTH accepted bits the word is
// complete and a one-cycle done pulse is issued. abort cancels a capture in
// progress without a done pulse and leaves the partial word visible.
//
// Optional feature macro: SHIFT_CTRL_PARITY_EN
//   Defined   : a PAR state follows SHIFT and accepts one extra valid bit as
//               even parity; parity_err reports (^data_out) ^ parity_bit in
//               the DONE cycle and stays until the next start.
//   Undefined : no PAR state, parity_err is tied to 0, same port list.
module shift_ctrl #(
  parameter int WIDTH = Pkg_Global::LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bin,
  input  logic             bin_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             parity_err
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef SHIFT_CTRL_PARITY_EN
    PAR   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             busy_q;
  logic             done_q;
  logic             busy_nxt;
  logic             done_nxt;
`ifdef SHIFT_CTRL_PARITY_EN
  logic             perr_q;
  logic             perr_nxt;
`endif

  // Append one serial bit at the LSB; older bits move toward the MSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                input logic             b);
    return {r[WIDTH-2:0], b};
  endfunction

  // Next-state, next register/counter and next registered status flags.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
`ifdef SHIFT_CTRL_PARITY_EN
    perr_nxt  = perr_q;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          shreg_nxt = '0;
          cnt_nxt   = '0;
`ifdef SHIFT_CTRL_PARITY_EN
          perr_nxt  = 1'b0;
`endif
        end
      end

      SHIFT: begin
        // abort wins over a valid bit in the same cycle; that bit is dropped.
        if (abort) begin
          state_nxt = IDLE;
        end else if (bin_valid) begin
          shreg_nxt = shift_in(shreg, bin);
          cnt_nxt   = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
`ifdef SHIFT_CTRL_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = DONE;
`endif
          end
        end
      end

`ifdef SHIFT_CTRL_PARITY_EN
      PAR: begin
        // The parity bit is checked against the word but never stored in it.
        if (abort) begin
          state_nxt = IDLE;
        end else if (bin_valid) begin
          perr_nxt  = (^shreg) ^ bin;
          state_nxt = DONE;
        end
      end
`endif

      DONE: begin
        // A start here is honoured immediately, giving back-to-back captures.
        if (start) begin
          state_nxt = SHIFT;
          shreg_nxt = '0;
          cnt_nxt   = '0;
`ifdef SHIFT_CTRL_PARITY_EN
          perr_nxt  = 1'b0;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Status flags are decoded from the next state and then registered so
    // the outputs come straight from flops and cannot glitch.
    busy_nxt = (state_nxt == SHIFT);
`ifdef SHIFT_CTRL_PARITY_EN
    busy_nxt = busy_nxt | (state_nxt == PAR);
`endif
    done_nxt = (state_nxt == DONE);
  end

  // State, datapath and status registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

`ifdef SHIFT_CTRL_PARITY_EN
  // Parity result register, valid from the DONE cycle until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_nxt;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out = shreg;
  assign busy     = busy_q;
  assign done     = done_q;

  // Structural invariants of the controller.
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_MAX);

  a_done_not_busy: assert property (@(posedge clk) disable iff (rst)
    !(done_q && busy_q));

  a_done_is_state: assert property (@(posedge clk) disable iff (rst)
    done_q == (state == DONE));

endmodule
